// File: rtl/lector_teclado.sv
// 4x4 keypad scanner: row scan, press debounce, one key_valid pulse per press, release filter.
// Optional macro LECTOR_DEBOUNCE_EN enables DEB_CYCLES filtering; otherwise a single sample is used.
module lector_teclado #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

`ifdef LECTOR_DEBOUNCE_EN
    localparam int unsigned DEB_N = DEB_CYCLES;
`else
    localparam int unsigned DEB_N = (DEB_CYCLES > 0) ? 1 : 1;
`endif

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  CNT_LAST   = 8'(DEB_N - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    state_t      state;
    logic [1:0]  row;
    logic [15:0] dwell;
    logic [7:0]  cnt;
    logic [3:0]  lat_pat;
    logic [1:0]  lat_col;

    function automatic logic [3:0] drive(input logic [1:0] r);
        logic [3:0] onehot;
        onehot = 4'b0001 << r;
        return ~onehot;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // cnt counts accepted samples minus one; exit happens at CNT_LAST so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SCAN;
            row         <= 2'd0;
            dwell       <= 16'd0;
            cnt         <= 8'd0;
            lat_pat     <= 4'hF;
            lat_col     <= 2'd0;
            row_out     <= 4'b1110;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= 16'd0;
                        if (col_in != 4'hF) begin
                            lat_pat <= col_in;
                            lat_col <= lowest_low(col_in);
                            cnt     <= 8'd0;
                            state   <= DEBOUNCE;
                        end else begin
                            row     <= row + 2'd1;
                            row_out <= drive(row + 2'd1);
                        end
                    end else begin
                        dwell <= dwell + 16'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_in == lat_pat) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= 8'd0;
                            state <= EMIT;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        cnt   <= 8'd0;
                        dwell <= 16'd0;
                        state <= SCAN;
                    end
                end
                EMIT: begin
                    key_code    <= {row, lat_col};
                    key_valid   <= 1'b1;
                    key_pressed <= 1'b1;
                    cnt         <= 8'd0;
                    state       <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Column changes within the held row only reset the release count.
                    if (col_in == 4'hF) begin
                        if (cnt == CNT_LAST) begin
                            cnt         <= 8'd0;
                            key_pressed <= 1'b0;
                            row         <= row + 2'd1;
                            row_out     <= drive(row + 2'd1);
                            dwell       <= 16'd0;
                            state       <= SCAN;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        cnt <= 8'd0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_lector_teclado.sv
// Randomized keypad bench: a keypad model drives col_in from row_out; expected outputs come from timing formulas.
module tb_lector_teclado;
    localparam int SD = 4;
    localparam int DB = 3;
`ifdef LECTOR_DEBOUNCE_EN
    localparam int DEB = DB;
`else
    localparam int DEB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col_in = 4'hF;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    int         errors = 0;
    int         checks = 0;
    int         e = 0;
    logic       pressed = 1'b0;
    int         krow = 0;
    logic [3:0] kpat = 4'hF;

    always #5 clk = ~clk;

    lector_teclado #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .col_in     (col_in),
        .row_out    (row_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [3:0] drv(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return ~v;
    endfunction

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++)
            if (!p[i]) return i;
        return 3;
    endfunction

    // Keypad: the pressed key's row pulls its columns low only while that row is driven.
    task automatic drive_keys();
        col_in = (pressed && row_out == drv(krow)) ? kpat : 4'hF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row_out"}, row_out, 4'b1110);
        check({tag, "_key_code"}, key_code, 4'h0);
        check({tag, "_key_valid"}, key_valid, 1'b0);
        check({tag, "_key_pressed"}, key_pressed, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        pressed = 1'b0;
        col_in = 4'h0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        check_reset_vals("reset");
        rst = 1'b1;
        e = 0;
        drive_keys();
    endtask

    task automatic idle_scan(input int n);
        do_reset(3);
        repeat (n) begin
            tick();
            check("idle_row", row_out, drv((e / SD) % 4));
            check("idle_kv", key_valid, 1'b0);
            drive_keys();
        end
    endtask

    // j>0: release bounces with j idle samples followed by one pressed sample.
    task automatic press_trial(input int r, input logic [3:0] p, input logic [3:0] p2,
                               input int h, input int j);
        int d, pv, s, rs, erel, lc;
        logic [3:0] code;
        logic [3:0] exp_row;
        d = SD * r + SD;
        pv = d + DEB + 1;
        s = pv + h / 2;
        rs = pv + h;
        erel = (j > 0) ? rs + j + 1 + DEB : rs + DEB;
        lc = lowest(p);
        code = {r[1:0], lc[1:0]};
        do_reset(2);
        krow = r;
        kpat = p;
        pressed = 1'b1;
        drive_keys();
        while (e < erel + 3 * SD) begin
            tick();
            if (e < d)         exp_row = drv((e / SD) % 4);
            else if (e < erel) exp_row = drv(r);
            else               exp_row = drv((r + 1 + (e - erel) / SD) % 4);
            check("press_row", row_out, exp_row);
            check("press_kv", key_valid, e == pv);
            check("press_kp", key_pressed, (e >= pv) && (e < erel));
            check("press_code", key_code, (e >= pv) ? code : 4'h0);
            if (e == s) kpat = p2;
            pressed = (e + 1 <= rs) || (j > 0 && e + 1 == rs + j + 1);
            drive_keys();
        end
    endtask

`ifdef LECTOR_DEBOUNCE_EN
    // Key held for the detection sample plus k matching samples, then let go.
    task automatic bounce_trial(input int r, input logic [3:0] p, input int k);
        int d, m;
        logic [3:0] exp_row;
        d = SD * r + SD;
        m = d + k + 1;
        do_reset(2);
        krow = r;
        kpat = p;
        pressed = 1'b1;
        drive_keys();
        while (e < m + 3 * SD) begin
            tick();
            if (e < d)      exp_row = drv((e / SD) % 4);
            else if (e < m) exp_row = drv(r);
            else            exp_row = drv((r + (e - m) / SD) % 4);
            check("bounce_row", row_out, exp_row);
            check("bounce_kv", key_valid, 1'b0);
            check("bounce_kp", key_pressed, 1'b0);
            pressed = (e + 1 <= d + k);
            drive_keys();
        end
    endtask
`endif

    task automatic abort_trial(input int r, input logic [3:0] p);
        int d;
        d = SD * r + SD;
        do_reset(2);
        krow = r;
        kpat = p;
        pressed = 1'b1;
        drive_keys();
        while (e < d + 1) begin
            tick();
            check("abort_kv", key_valid, 1'b0);
            drive_keys();
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_reset_vals("abort");
        end
        pressed = 1'b0;
        rst = 1'b1;
        e = 0;
        drive_keys();
        repeat (3 * SD) begin
            tick();
            check("resume_row", row_out, drv((e / SD) % 4));
            check("resume_kv", key_valid, 1'b0);
            drive_keys();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int r, h, j, k;
        logic [3:0] p, p2;
        idle_scan(20);
        press_trial(2, 4'b1101, 4'b1101, 6, 0);
        press_trial(1, 4'b0110, 4'b0011, 50, 0);
`ifdef LECTOR_DEBOUNCE_EN
        bounce_trial(0, 4'b1110, 1);
`endif
        abort_trial(1, 4'b1011);
        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(0, 3);
            p = 4'($urandom_range(0, 14));
            p2 = 4'($urandom_range(0, 14));
            h = $urandom_range(4, 50);
            j = $urandom_range(0, DEB - 1);
            press_trial(r, p, p2, h, j);
        end
`ifdef LECTOR_DEBOUNCE_EN
        for (int t = 0; t < 6; t++) begin
            r = $urandom_range(0, 3);
            p = 4'($urandom_range(0, 14));
            k = $urandom_range(0, DEB - 1);
            bounce_trial(r, p, k);
        end
`endif
        for (int t = 0; t < 3; t++) begin
            r = $urandom_range(0, 3);
            p = 4'($urandom_range(0, 14));
            abort_trial(r, p);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lector_teclado.md
LECTOR_TECLADO -- requirements
Module: lector_teclado

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each row is driven during scanning; legal range 2..65535.
REQ-002 Parameter DEB_CYCLES, default 16: consecutive matching samples needed to accept a press or a release; legal range 1..255.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 col_in  input  4  keypad columns, already synchronized; active-low (0 = pressed).
REQ-006 row_out  output  4  keypad row drive; active-low one-hot.
REQ-007 key_code  output  4  last accepted key, {row[1:0], col[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse when key_code updates.
REQ-009 key_pressed  output  1  level; high from acceptance until release is accepted.

Function
REQ-010 The block SHALL implement the FSM states SCAN, DEBOUNCE, EMIT and WAIT_RELEASE.
REQ-011 SCAN: row_out SHALL equal ~(1<<row); a dwell counter SHALL count 0..SCAN_DIV-1, and at SCAN_DIV-1 row SHALL advance, wrapping 3->0.
REQ-012 SCAN: col_in SHALL be examined only when dwell = SCAN_DIV-1; if any bit is 0, row and col_in SHALL be latched, the FSM SHALL go to DEBOUNCE, and row SHALL NOT advance.
REQ-013 Multiple low columns: the lowest-index low column SHALL be the col used for key_code; the full latched pattern SHALL be used for matching.
REQ-014 DEBOUNCE: row_out SHALL hold the latched row; each cycle col_in equal to the latched pattern SHALL increment the match counter.
REQ-015 DEBOUNCE: any mismatch SHALL return to SCAN on the same row with dwell cleared.
REQ-016 DEBOUNCE: on reaching DEB_CYCLES matches, the FSM SHALL go to EMIT.
REQ-017 EMIT: key_code SHALL load {row, col}, key_valid SHALL be 1 for exactly one cycle, key_pressed SHALL go high, and the next state SHALL be WAIT_RELEASE.
REQ-018 Latency: key_valid SHALL rise DEB_CYCLES+1 cycles after the detection edge.
REQ-019 WAIT_RELEASE: row_out SHALL hold the latched row.
REQ-020 WAIT_RELEASE: DEB_CYCLES consecutive samples of col_in = 4'hF SHALL clear key_pressed and return to SCAN on the next row with dwell 0.
REQ-021 WAIT_RELEASE: any sample other than 4'hF SHALL restart the release count.
REQ-022 WAIT_RELEASE: a change of column within the held row SHALL NOT generate a new key_valid; one press yields exactly one pulse.
REQ-023 key_code SHALL hold its value between EMIT states.
REQ-024 key_valid SHALL be 0 in every state other than EMIT.
REQ-025 Counters SHALL be sized for the parameter maxima and SHALL never wrap in DEBOUNCE or WAIT_RELEASE (saturate or exit first).

Reset
REQ-026 While rst=0 at a clock edge: state = SCAN, row = 0, dwell = 0, match count = 0, row_out = 4'b1110, key_code = 4'h0, key_valid = 0, key_pressed = 0.
REQ-027 Reset asserted in any state SHALL abort the operation with no key_valid pulse.
REQ-028 Scanning SHALL resume at row 0 on the first edge after rst returns high.

Configuration
REQ-029 Macro LECTOR_DEBOUNCE_EN defined: DEBOUNCE and release filtering SHALL behave as REQ-014 to REQ-021 using DEB_CYCLES.
REQ-030 Macro LECTOR_DEBOUNCE_EN undefined: DEB_CYCLES SHALL be ignored and treated as 1.
REQ-031 Without the macro, DEBOUNCE SHALL last one cycle (single matching sample), release SHALL be accepted on the first 4'hF sample, and latency SHALL be 2 cycles.

Verification (SCAN_DIV=4, DEB_CYCLES=3, macro defined unless noted)
REQ-032 Reset: hold rst=0 for 3 cycles, col_in=4'h0 -> row_out=4'b1110, key_code=0, key_valid=0, key_pressed=0.
REQ-033 Idle scan: col_in=4'hF for 20 cycles -> row_out 1110,1101,1011,0111,1110, each held 4 cycles, no key_valid.
REQ-034 Clean press, row 2 col 1: col_in=4'b1101 while row 2 is driven -> key_valid pulses 4 cycles after detection, key_code=4'h9, key_pressed=1.
REQ-034a Release of REQ-034: col_in=4'hF for 3 cycles -> key_pressed=0 and scan resumes at row 3.
REQ-035 Bounce: col_in=4'b1110 for 2 cycles then 4'hF during DEBOUNCE -> no key_valid; row 0 rescanned with dwell restarted.
REQ-036 Simultaneous keys: col_in=4'b0110 on row 1 -> key_code=4'h4 (lowest column 0), exactly one pulse.
REQ-036a Held key: keep col_in low for 50 cycles after REQ-036 -> still exactly one pulse.
REQ-037 Reset mid-operation: rst=0 on the 2nd DEBOUNCE cycle -> no pulse, all outputs at reset values.
REQ-037a Macro undefined: a press is reported 2 cycles after detection, and a 1-cycle 4'hF sample releases it.
